// File: rtl/layer_1_result_reader_if.sv
// Result stream bundle between the layer-1 multiplier, this reader and its consumer.
// The master side belongs to the reader; the slave side to the producer/consumer.
interface layer_1_result_reader_if #(
  parameter int unsigned NUM_OUTPUTS = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IDX_WIDTH   = 5
);
  logic                                done;
  logic [NUM_OUTPUTS*DATA_WIDTH-1:0]   layer_1_outputs;
  logic                                relu_en;
  logic                                out_ready;
  logic                                out_valid;
  logic [DATA_WIDTH-1:0]               out_data;
  logic [IDX_WIDTH-1:0]                out_index;
  logic                                out_last;

  modport master (
    input  done, layer_1_outputs, relu_en, out_ready,
    output out_valid, out_data, out_index, out_last
  );

  modport slave (
    output done, layer_1_outputs, relu_en, out_ready,
    input  out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/layer_1_result_reader.sv
// Captures one frame of layer-1 accumulator results on done and streams them out
// word by word over a valid/ready handshake, with optional ReLU applied at capture.
module layer_1_result_reader #(
  parameter int unsigned NUM_OUTPUTS = 20,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned IDX_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  layer_1_result_reader_if.master bus,
  input  logic                    clear_overrun,
  output logic                    busy,
  output logic                    overrun,
  output logic [7:0]              frame_count
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_OUTPUTS - 1);

  typedef enum logic {StIdle, StStream} state_e;

  state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            frame_count_q, frame_count_d;
  logic [DATA_WIDTH-1:0] buf_q   [NUM_OUTPUTS];
  logic [DATA_WIDTH-1:0] cap_data[NUM_OUTPUTS];
  logic                  capture;
  logic                  xfer;
  logic                  at_last;

  always_comb begin
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      cap_data[k] = (bus.relu_en && bus.layer_1_outputs[k*DATA_WIDTH + DATA_WIDTH - 1]) ?
                    '0 : bus.layer_1_outputs[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign xfer    = (state_q == StStream) && bus.out_ready;
  assign at_last = (idx_q == LastIdx);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    overrun_d     = overrun_q;
    frame_count_d = frame_count_q;
    capture       = 1'b0;

    if (clear_overrun) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.done) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        if (xfer && at_last) begin
          frame_count_d = frame_count_q + 8'd1;
          // A done landing on the final transfer starts the next frame seamlessly.
          if (bus.done) begin
            capture = 1'b1;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
          if (bus.done) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        buf_q[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < NUM_OUTPUTS; k++) begin
        buf_q[k] <= cap_data[k];
      end
    end
  end

  // Index is left in place after draining, so data/index naturally hold in idle.
  always_comb begin
    bus.out_valid = (state_q == StStream);
    bus.out_data  = buf_q[idx_q];
    bus.out_index = idx_q;
    bus.out_last  = (state_q == StStream) && at_last;
    busy          = (state_q == StStream);
    overrun       = overrun_q;
    frame_count   = frame_count_q;
  end

endmodule

// File: tb/tb_layer_1_result_reader.sv
// Directed bench for layer_1_result_reader: stimulus pushes expected words into a
// scoreboard queue, a negedge monitor pops and compares on every accepted transfer.
module tb_layer_1_result_reader;

  localparam int unsigned N  = 20;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 5;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_overrun;
  logic       busy;
  logic       overrun;
  logic [7:0] frame_count;

  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  exp_t sb[$];

  layer_1_result_reader_if #(.NUM_OUTPUTS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  layer_1_result_reader #(.NUM_OUTPUTS(N), .DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .clear_overrun (clear_overrun),
    .busy          (busy),
    .overrun       (overrun),
    .frame_count   (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: transfers are decided by valid&ready just before the rising edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      xfers++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got idx %0d data %0h, expected none",
                 bus.out_index, bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", 32'(bus.out_data), 32'(e.data));
        check("sb_index", 32'(bus.out_index), 32'(e.idx));
        check("sb_last", 32'(bus.out_last), 32'(e.last));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*DW-1:0] make_vec(input int base, input int step);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + step * (k + 1));
    return v;
  endfunction

  task automatic push_frame(input logic [N*DW-1:0] v, input logic relu);
    for (int k = 0; k < N; k++) begin
      exp_t e;
      logic [DW-1:0] w;
      w      = v[k*DW +: DW];
      e.data = (relu && w[DW-1]) ? '0 : w;
      e.idx  = IW'(k);
      e.last = (k == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    @(posedge clk); #1;
    bus.done = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=1, expected 0 within 200 cycles");
    end
  endtask

  task automatic wait_index(input int idx);
    int n = 0;
    while (!(bus.out_valid && bus.out_index == IW'(idx)) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_index", 32'(bus.out_index), 32'(idx));
  endtask

  logic [N*DW-1:0] va, vb;
  logic            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset               = 1'b1;
    clear_overrun       = 1'b0;
    bus.done            = 1'b0;
    bus.relu_en         = 1'b0;
    bus.out_ready       = 1'b0;
    bus.layer_1_outputs = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_data", 32'(bus.out_data), 0);
    check("rst_index", 32'(bus.out_index), 0);
    check("rst_last", 32'(bus.out_last), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_fc", 32'(frame_count), 0);

    // Basic frame k*3, ready held high.
    va = make_vec(0, 3);
    bus.layer_1_outputs = va;
    bus.out_ready = 1'b1;
    push_frame(va, 1'b0);
    pulse_done();
    check("latency_valid", 32'(bus.out_valid), 1);
    check("latency_index", 32'(bus.out_index), 0);
    check("first_data", 32'(bus.out_data), 3);
    wait_idle();
    check("t1_fc", 32'(frame_count), 1);
    check("t1_valid", 32'(bus.out_valid), 0);
    check("t1_last", 32'(bus.out_last), 0);
    check("t1_hold_index", 32'(bus.out_index), 19);
    check("t1_hold_data", 32'(bus.out_data), 60);

    // ReLU on and off.
    vb = '0;
    vb[15:0]  = 16'hFFF6;
    vb[31:16] = 16'h0005;
    bus.layer_1_outputs = vb;
    bus.relu_en = 1'b1;
    push_frame(vb, 1'b1);
    pulse_done();
    check("relu_w0", 32'(bus.out_data), 0);
    wait_idle();
    bus.relu_en = 1'b0;
    push_frame(vb, 1'b0);
    pulse_done();
    check("norelu_w0", 32'(bus.out_data), 32'h0000FFF6);
    wait_idle();
    check("t2_fc", 32'(frame_count), 3);

    // Backpressure 1,0,0,1.
    va = make_vec(100, 7);
    bus.layer_1_outputs = va;
    xfers = 0;
    push_frame(va, 1'b0);
    pulse_done();
    for (int i = 0; i < 200 && busy; i++) begin
      bus.out_ready = pat[i % 4];
      @(posedge clk); #1;
    end
    check("bp_xfers", 32'(xfers), 20);
    check("t3_fc", 32'(frame_count), 4);
    bus.out_ready = 1'b1;

    // Overrun at index 7: stream keeps original data.
    va = make_vec(0, 3);
    vb = make_vec(16'h1000, 1);
    bus.layer_1_outputs = va;
    push_frame(va, 1'b0);
    pulse_done();
    wait_index(7);
    bus.layer_1_outputs = vb;
    pulse_done();
    check("ovr_set", 32'(overrun), 1);
    check("ovr_index", 32'(bus.out_index), 8);
    wait_idle();
    check("ovr_sticky", 32'(overrun), 1);
    clear_overrun = 1'b1;
    @(posedge clk); #1;
    clear_overrun = 1'b0;
    check("ovr_clear", 32'(overrun), 0);
    check("t4_fc", 32'(frame_count), 5);

    // Done coincident with final transfer.
    bus.layer_1_outputs = va;
    push_frame(va, 1'b0);
    pulse_done();
    wait_index(19);
    bus.layer_1_outputs = vb;
    push_frame(vb, 1'b0);
    pulse_done();
    check("b2b_index", 32'(bus.out_index), 0);
    check("b2b_data", 32'(bus.out_data), 32'h1001);
    check("b2b_overrun", 32'(overrun), 0);
    check("b2b_busy", 32'(busy), 1);
    check("b2b_fc", 32'(frame_count), 6);
    wait_idle();
    check("t5_fc", 32'(frame_count), 7);

    // Reset mid-stream.
    bus.layer_1_outputs = va;
    push_frame(va, 1'b0);
    pulse_done();
    wait_index(10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    check("mrst_valid", 32'(bus.out_valid), 0);
    check("mrst_data", 32'(bus.out_data), 0);
    check("mrst_index", 32'(bus.out_index), 0);
    check("mrst_last", 32'(bus.out_last), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_fc", 32'(frame_count), 0);

    // 256 frames wrap frame_count.
    for (int f = 0; f < 256; f++) begin
      push_frame(va, 1'b0);
      pulse_done();
      wait_idle();
      if (f == 254) check("fc_255", 32'(frame_count), 255);
    end
    check("fc_wrap", 32'(frame_count), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
